// File: rtl/seg_anim_ctrl.sv
// Purpose: 7-segment animation controller (chase / sweep / bounce) with debounced mode buttons and a ms/step timebase.
// Latency: seg_n follows mode/frame/msg_sel by 1 clk; frame updates on the step-strobe edge; buttons settle after DEBOUNCE_MS.
// Backpressure: none, free-running; pause holds the frame while step strobes keep pulsing.
module seg_anim_ctrl #(
    parameter int CLOCK_MHZ   = 50,
    parameter int NUM_DIGITS  = 4,
    parameter int STEP_MS     = 500,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              btn_n,
    input  logic                    pause,
    input  logic                    dir,
    input  logic [1:0]              speed,
    input  logic                    msg_sel,
    output logic [7*NUM_DIGITS-1:0] seg_n,
    output logic [1:0]              mode,
    output logic [4:0]              frame,
    output logic                    step
);

    localparam int N = NUM_DIGITS;
    localparam int SEGW = 7 * N;
    localparam logic [7:0] US_LAST = 8'(CLOCK_MHZ - 1);
    localparam logic [9:0] MS_LAST = 10'd999;
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_MS - 1);

    typedef enum logic [1:0] {
        M_IDLE   = 2'd0,
        M_CHASE  = 2'd1,
        M_SWEEP  = 2'd2,
        M_BOUNCE = 2'd3
    } mode_t;

    mode_t mode_q, mode_d;

    logic [7:0]  us_cnt;
    logic [9:0]  ms_cnt;
    logic [10:0] step_cnt;
    logic [10:0] step_last;
    logic        us_tick, ms_tick, step_tick;

    logic [2:0]  sync1, sync2, deb;
    logic [7:0]  db_cnt [3];
    logic [2:0]  press;
    logic        mode_chg;

    logic [4:0]  frame_last, frame_nxt;
    logic [SEGW-1:0] lit;
    int          k, p;

    assign us_tick = (us_cnt == US_LAST);
    assign ms_tick = us_tick && (ms_cnt == MS_LAST);

    always_comb begin
        step_last = 11'(STEP_MS - 1);
        case (speed)
            2'b01:   step_last = 11'(STEP_MS / 2 - 1);
            2'b10:   step_last = 11'(STEP_MS / 4 - 1);
            2'b11:   step_last = 11'(STEP_MS * 2 - 1);
            default: step_last = 11'(STEP_MS - 1);
        endcase
    end

    // >= so that shortening the period mid-count fires at the next ms strobe
    assign step_tick = ms_tick && (step_cnt >= step_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            us_cnt   <= '0;
            ms_cnt   <= '0;
            step_cnt <= '0;
            step     <= 1'b0;
        end else begin
            us_cnt <= us_tick ? '0 : us_cnt + 8'd1;
            if (us_tick)
                ms_cnt <= ms_tick ? '0 : ms_cnt + 10'd1;
            if (mode_chg)
                step_cnt <= '0;
            else if (ms_tick)
                step_cnt <= step_tick ? '0 : step_cnt + 11'd1;
            step <= step_tick;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (ms_tick) begin
                    if (db_cnt[i] == DB_LAST) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 8'd1;
                    end
                end
            end
        end
    end

    // press fires on the same edge the debounced level drops to 0
    always_comb begin
        press = '0;
        for (int i = 0; i < 3; i++)
            press[i] = ms_tick && (sync2[i] != deb[i]) && (db_cnt[i] == DB_LAST) && !sync2[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mode_q <= M_IDLE;
        else        mode_q <= mode_d;
    end

    always_comb begin
        mode_d = mode_q;
        if (press[0])
            mode_d = (mode_q == M_CHASE) ? M_IDLE : M_CHASE;
        else if (press[1])
            mode_d = (mode_q == M_SWEEP) ? M_IDLE : M_SWEEP;
        else if (press[2])
            mode_d = (mode_q == M_BOUNCE) ? M_IDLE : M_BOUNCE;
    end

    assign mode_chg = (mode_d != mode_q);
    assign mode     = mode_q;

    always_comb begin
        frame_last = 5'd0;
        case (mode_q)
            M_CHASE:  frame_last = 5'(2 * N + 3);
            M_SWEEP:  frame_last = 5'd5;
            M_BOUNCE: frame_last = 5'(2 * N - 3);
            default:  frame_last = 5'd0;
        endcase
        if (!dir)
            frame_nxt = (frame >= frame_last) ? 5'd0 : frame + 5'd1;
        else
            frame_nxt = (frame == 5'd0) ? frame_last : frame - 5'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame <= '0;
        else if (mode_chg)
            frame <= '0;
        else if (step_tick && !pause)
            frame <= frame_nxt;
    end

    // lit is active-high; digit d owns bits [7d+6:7d], a..g
    always_comb begin
        lit = '0;
        k   = int'(frame);
        p   = (k < N) ? k : (2 * N - 2 - k);
        for (int d = 0; d < N; d++) begin
            case (mode_q)
                M_CHASE: begin
                    if (k == N - 1 - d)                   lit[7*d+0] = 1'b1;
                    if (d == 0 && k == N)                 lit[7*d+1] = 1'b1;
                    if (d == 0 && k == N + 1)             lit[7*d+2] = 1'b1;
                    if (k == N + 2 + d)                   lit[7*d+3] = 1'b1;
                    if (d == N - 1 && k == 2 * N + 2)     lit[7*d+4] = 1'b1;
                    if (d == N - 1 && k == 2 * N + 3)     lit[7*d+5] = 1'b1;
                end
                M_SWEEP: begin
                    for (int s = 0; s < 6; s++)
                        if (k == s) lit[7*d+s] = 1'b1;
                end
                M_BOUNCE: begin
                    if (p == N - 1 - d) lit[7*d+6] = 1'b1;
                end
                default: begin
                    if (msg_sel) lit[7*d+6] = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seg_n <= '1;
        else        seg_n <= ~lit;
    end

endmodule

// File: tb/tb_seg_anim_ctrl.sv
// Directed bench for seg_anim_ctrl at N=4, 2 MHz, 4 ms step, 2 ms debounce (1 ms = 2000 clk).
module tb_seg_anim_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  btn_n = 3'b111;
    logic        pause = 1'b0;
    logic        dir = 1'b0;
    logic [1:0]  speed = 2'b00;
    logic        msg_sel = 1'b0;
    logic [27:0] seg_n;
    logic [1:0]  mode;
    logic [4:0]  frame;
    logic        step;

    int n_checks = 0;
    int n_errors = 0;
    int n;

    seg_anim_ctrl #(
        .CLOCK_MHZ  (2),
        .NUM_DIGITS (4),
        .STEP_MS    (4),
        .DEBOUNCE_MS(2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_n  (btn_n),
        .pause  (pause),
        .dir    (dir),
        .speed  (speed),
        .msg_sel(msg_sel),
        .seg_n  (seg_n),
        .mode   (mode),
        .frame  (frame),
        .step   (step)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] one_lit(input int b);
        logic [31:0] v;
        v = 32'h0FFF_FFFF & ~(32'h1 << b);
        return v;
    endfunction

    // Cycles from call until step is seen high; bounded.
    task automatic wait_step(input int max, output int cyc);
        cyc = 0;
        for (int i = 0; i < max; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (step) break;
        end
        check("step_seen", 32'(step), 32'd1);
    endtask

    task automatic press(input int b);
        btn_n[b] = 1'b0;
        repeat (6000) @(negedge clk);
        btn_n[b] = 1'b1;
        repeat (4100) @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_seg", 32'(seg_n), 32'h0FFF_FFFF);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_frame", 32'(frame), 32'd0);
        check("rst_step", 32'(step), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_blank", 32'(seg_n), 32'h0FFF_FFFF);

        // chase entry, then first step at normal speed
        press(0);
        check("chase_mode", 32'(mode), 32'd1);
        check("chase_f0", 32'(frame), 32'd0);
        check("chase_seg0", 32'(seg_n), one_lit(21));
        wait_step(10000, n);
        check("chase_f1", 32'(frame), 32'd1);
        check("seg_lag", 32'(seg_n), one_lit(21));
        next_cycle();
        check("chase_seg1", 32'(seg_n), one_lit(14));

        // 1 ms period; one cycle already spent after the previous step
        speed = 2'b10;
        dir   = 1'b1;
        wait_step(3000, n);
        check("fast_period", 32'(n), 32'd1999);
        check("chase_dec", 32'(frame), 32'd0);
        wait_step(3000, n);
        check("chase_rwrap", 32'(frame), 32'd11);
        next_cycle();
        check("chase_seg11", 32'(seg_n), one_lit(26));
        dir = 1'b0;
        wait_step(3000, n);
        check("chase_wrap", 32'(frame), 32'd0);
        next_cycle();
        check("chase_wrap_seg", 32'(seg_n), one_lit(21));

        pause = 1'b1;
        wait_step(3000, n);
        check("pause_hold", 32'(frame), 32'd0);

        // asynchronous reset mid-chase
        #2 rst_n = 1'b0;
        #1;
        check("arst_seg", 32'(seg_n), 32'h0FFF_FFFF);
        check("arst_mode", 32'(mode), 32'd0);
        check("arst_frame", 32'(frame), 32'd0);
        repeat (3) @(negedge clk);
        speed = 2'b00;
        pause = 1'b0;
        rst_n = 1'b1;
        wait_step(10000, n);
        check("first_step", 32'(n), 32'd8000);
        check("resume_idle", 32'(mode), 32'd0);

        // 1 ms glitch must not register
        btn_n[2] = 1'b0;
        repeat (2000) @(negedge clk);
        btn_n[2] = 1'b1;
        repeat (4100) @(negedge clk);
        check("glitch_mode", 32'(mode), 32'd0);

        // bounce, reverse wrap
        pause = 1'b1;
        speed = 2'b10;
        press(2);
        check("bounce_mode", 32'(mode), 32'd3);
        check("bounce_seg0", 32'(seg_n), one_lit(27));
        pause = 1'b0;
        dir   = 1'b1;
        wait_step(3000, n);
        check("bounce_rwrap", 32'(frame), 32'd5);
        next_cycle();
        check("bounce_seg5", 32'(seg_n), one_lit(20));

        // sweep on, then toggle off
        pause = 1'b1;
        press(1);
        check("sweep_mode", 32'(mode), 32'd2);
        check("sweep_f0", 32'(frame), 32'd0);
        check("sweep_seg0", 32'(seg_n), 32'h0FFF_FFFF & ~32'h0204081);
        press(1);
        check("toggle_off", 32'(mode), 32'd0);
        check("toggle_blank", 32'(seg_n), 32'h0FFF_FFFF);

        msg_sel = 1'b1;
        next_cycle();
        check("idle_dash", 32'(seg_n), 32'h07EF_DFBF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
